// File: rtl/round_key_store.sv
// round_key_store: dual-bank (direct/inverse) AES round key storage with registered reads
module round_key_store #(
  parameter int KEY_SLOTS = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_start,
  input  logic [1:0]   key_length,
  input  logic         key_in_valid,
  input  logic [0:127] key_in_direct,
  input  logic [0:127] key_in_inverse,
  input  logic         rd_req,
  input  logic         rd_decrypt,
  input  logic [3:0]   rd_round,
  output logic         rd_valid,
  output logic [0:127] rd_key,
  output logic         keys_ready,
  output logic [3:0]   num_rounds,
  output logic         load_error
);
  typedef enum logic [1:0] {IDLE, LOADING, READY} state_t;
  state_t state, next;
  logic [3:0] nr, cnt;
  logic [0:127] dir_bank [KEY_SLOTS];
  logic [0:127] inv_bank [KEY_SLOTS];
  logic bad, wr, done, rd_ok;
  assign bad = key_length == 2'b11;
  assign wr = state == LOADING && key_in_valid && !load_start;
  assign done = wr && cnt == nr;
  assign rd_ok = rd_req && state == READY && rd_round <= nr;
  assign keys_ready = state == READY;
  assign num_rounds = keys_ready ? nr : 4'd0;
  always_comb next = load_start ? (bad ? IDLE : LOADING) : done ? READY : state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      nr <= '0;
      cnt <= '0;
      load_error <= 1'b0;
      rd_valid <= 1'b0;
      rd_key <= '0;
    end else begin
      state <= next;
      load_error <= load_start && bad;
      rd_valid <= rd_ok;
      rd_key <= !rd_ok ? '0 : rd_decrypt ? inv_bank[nr - rd_round] : dir_bank[rd_round];
      if (load_start && !bad) begin
        nr <= 4'd10 + {1'b0, key_length, 1'b0};
        cnt <= '0;
      end else if (wr && !done) cnt <= cnt + 4'd1;
    end
  end
  // Bank contents need no reset: nothing is readable until a full schedule lands.
  always_ff @(posedge clk) begin
    if (wr) begin
      dir_bank[cnt] <= key_in_direct;
      inv_bank[cnt] <= key_in_inverse;
    end
  end
endmodule

// File: tb/tb_round_key_store.sv
// tb_round_key_store: directed AES load scenarios plus randomized traffic against a behavioural model
module tb_round_key_store;
  logic clk = 0, rst = 1, load_start = 0, key_in_valid = 0, rd_req = 0, rd_decrypt = 0;
  logic [1:0] key_length = 0;
  logic [3:0] rd_round = 0;
  logic [0:127] key_in_direct = 0, key_in_inverse = 0;
  logic rd_valid, keys_ready, load_error;
  logic [0:127] rd_key;
  logic [3:0] num_rounds;
  int n_total = 0, n_pass = 0;
  bit chk_en = 0;

  round_key_store dut (
    .clk(clk), .rst(rst), .load_start(load_start), .key_length(key_length),
    .key_in_valid(key_in_valid), .key_in_direct(key_in_direct), .key_in_inverse(key_in_inverse),
    .rd_req(rd_req), .rd_decrypt(rd_decrypt), .rd_round(rd_round), .rd_valid(rd_valid),
    .rd_key(rd_key), .keys_ready(keys_ready), .num_rounds(num_rounds), .load_error(load_error)
  );

  always #5 clk = ~clk;

  // Model: a schedule is a list of beats collected since the last good load_start;
  // it becomes readable once Nr+1 beats are in.
  logic [127:0] m_dir [15], m_inv [15];
  int m_nr = 0, m_got = 0;
  bit m_loading = 0, m_ready = 0;
  logic e_valid = 0, e_err = 0;
  logic [127:0] e_key = 0;

  initial for (int i = 0; i < 15; i++) begin m_dir[i] = 0; m_inv[i] = 0; end

  always @(posedge clk) begin
    if (rst) begin
      m_loading = 0; m_ready = 0; m_nr = 0; m_got = 0;
      e_valid = 0; e_key = 0; e_err = 0;
    end else begin
      e_valid = rd_req && m_ready && int'(rd_round) <= m_nr;
      e_key = !e_valid ? 128'h0 : rd_decrypt ? m_inv[m_nr - int'(rd_round)] : m_dir[rd_round];
      e_err = load_start && key_length == 2'b11;
      if (load_start) begin
        m_ready = 0;
        m_loading = key_length != 2'b11;
        m_got = 0;
        if (m_loading) m_nr = 10 + 2 * int'(key_length);
      end else if (m_loading && key_in_valid) begin
        m_dir[m_got] = key_in_direct;
        m_inv[m_got] = key_in_inverse;
        m_got++;
        if (m_got == m_nr + 1) begin m_loading = 0; m_ready = 1; end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("m_rd_valid", 128'(rd_valid), 128'(e_valid));
    chk("m_rd_key", rd_key, e_key);
    chk("m_keys_ready", 128'(keys_ready), 128'(m_ready));
    chk("m_num_rounds", 128'(num_rounds), m_ready ? 128'(m_nr) : 128'h0);
    chk("m_load_error", 128'(load_error), 128'(e_err));
  end

  task automatic cyc(); @(negedge clk); endtask

  task automatic load(input logic [1:0] kl);
    load_start = 1; key_length = kl;
    key_in_valid = 1; key_in_direct = 128'hdead; key_in_inverse = 128'hbeef;
    cyc();
    load_start = 0; key_in_valid = 0;
  endtask

  task automatic beat(input logic [127:0] d, input logic [127:0] v);
    key_in_valid = 1; key_in_direct = d; key_in_inverse = v;
    cyc();
    key_in_valid = 0;
  endtask

  task automatic rd(input logic dec, input logic [3:0] r);
    rd_req = 1; rd_decrypt = dec; rd_round = r;
    cyc();
    rd_req = 0;
  endtask

  initial begin
    cyc(); cyc();
    chk_en = 1;
    rst = 0;
    cyc();
    chk("reset_ready", 128'(keys_ready), 0);
    chk("reset_nr", 128'(num_rounds), 0);
    chk("reset_rd_valid", 128'(rd_valid), 0);
    // AES-128, consecutive beats
    load(2'b00);
    for (int i = 0; i < 11; i++) begin
      beat(128'(i), 128'h100 + 128'(i));
      if (i == 9) chk("a128_not_ready", 128'(keys_ready), 0);
    end
    chk("a128_ready", 128'(keys_ready), 1);
    chk("a128_nr", 128'(num_rounds), 10);
    rd(0, 3);
    chk("a128_rd3_enc", rd_key, 128'h3);
    rd(1, 3);
    chk("a128_rd3_dec", rd_key, 128'h107);
    // AES-256 with 2-cycle gaps
    load(2'b10);
    for (int i = 0; i < 15; i++) begin
      beat(128'h1000 + 128'(i), 128'h200 + 128'(i));
      if (i < 14) begin cyc(); cyc(); end
    end
    chk("a256_ready", 128'(keys_ready), 1);
    chk("a256_nr", 128'(num_rounds), 14);
    rd(1, 14);
    chk("a256_rd14_dec", rd_key, 128'h200);
    rd(0, 15);
    chk("a256_rd15_valid", 128'(rd_valid), 0);
    chk("a256_rd15_key", rd_key, 0);
    // Reload AES-128 while READY, with a read in the load_start cycle
    load_start = 1; key_length = 2'b00; rd_req = 1; rd_decrypt = 0; rd_round = 5;
    cyc();
    load_start = 0; rd_req = 0;
    chk("reload_old_key", rd_key, 128'h1005);
    chk("reload_old_valid", 128'(rd_valid), 1);
    chk("reload_not_ready", 128'(keys_ready), 0);
    for (int i = 0; i < 12; i++) beat(128'h3000 + 128'(i), 128'h4000 + 128'(i));
    chk("reload_nr", 128'(num_rounds), 10);
    rd(0, 10);
    chk("reload_rd10", rd_key, 128'h300a);
    rd(1, 0);
    chk("reload_rd0_dec", rd_key, 128'h400a);
    // Reserved key length
    load(2'b11);
    chk("err_pulse", 128'(load_error), 1);
    chk("err_ready", 128'(keys_ready), 0);
    chk("err_nr", 128'(num_rounds), 0);
    cyc();
    chk("err_pulse_end", 128'(load_error), 0);
    for (int i = 0; i < 5; i++) beat(128'(i), 128'(i));
    rd(0, 1);
    chk("err_rd_valid", 128'(rd_valid), 0);
    // Reset mid AES-192 load
    load(2'b01);
    for (int i = 0; i < 5; i++) beat(128'(i), 128'(i));
    rst = 1; cyc(); rst = 0;
    chk("rst_ready", 128'(keys_ready), 0);
    for (int i = 0; i < 8; i++) beat(128'(i), 128'(i));
    chk("rst_ready_after", 128'(keys_ready), 0);
    rd(0, 2);
    chk("rst_rd_valid", 128'(rd_valid), 0);
    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst = $urandom_range(0, 299) == 0;
      load_start = $urandom_range(0, 59) == 0;
      key_length = 2'($urandom_range(0, 3));
      key_in_valid = $urandom_range(0, 9) < 6;
      key_in_direct = {$urandom, $urandom, $urandom, $urandom};
      key_in_inverse = {$urandom, $urandom, $urandom, $urandom};
      rd_req = $urandom_range(0, 1) == 1;
      rd_decrypt = $urandom_range(0, 1) == 1;
      rd_round = 4'($urandom_range(0, 15));
      cyc();
    end
    rst = 0; load_start = 0; key_in_valid = 0; rd_req = 0;
    cyc();
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
